des_iterative_engine: RTL

DES_ITERATIVE_ENGINE -- requirements
Module: des_iterative_engine

---
 rtl/des_pkg.sv | 195 +++++++++++++++++++
 rtl/des_round.sv | 43 ++++
 rtl/des_iterative_engine.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES tables and helpers: IP, FP, E, P, PC1, PC2, S-boxes, the
// key rotation schedule, and the engine FSM state type.
// Table entries use the standard 1-based, MSB-first bit numbering.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } des_state_e;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // SHIFT[1..16] stored at index 0..15
  localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Row-major: entry = row*16 + column
  localparam int SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  // Permutations build the result MSB-first by shifting in one source bit per table entry.
  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y = {y[62:0], x[6'(64 - IP_TAB[j])]};
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y = {y[62:0], x[6'(64 - FP_TAB[j])]};
    return y;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y = {y[46:0], x[5'(32 - E_TAB[j])]};
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int j = 0; j < 32; j++) y = {y[30:0], x[5'(32 - P_TAB[j])]};
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int j = 0; j < 56; j++) y = {y[54:0], x[6'(64 - PC1_TAB[j])]};
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y = {y[46:0], x[6'(56 - PC2_TAB[j])]};
    return y;
  endfunction

  // Eight 6->4 lookups; row is the outer bit pair, column the inner four bits.
  function automatic logic [31:0] des_sbox(input logic [47:0] x);
    logic [31:0] y;
    logic [47:0] t;
    logic [5:0]  b;
    y = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      b = t[47:42];
      t = {t[41:0], 6'd0};
      y = {y[27:0], 4'(SBOX[3'(i)][{b[5], b[0], b[4:1]}])};
    end
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // Rotation applied before round rnd (1..16). Decrypt walks the schedule
  // backwards: round 1 uses C16/D16 (== C0/D0) as-is, later rounds undo SHIFT[18-rnd].
  function automatic logic [1:0] round_shift(input logic [4:0] rnd, input logic dec);
    if (!dec)             return 2'(SHIFT_TAB[4'(rnd - 5'd1)]);
    else if (rnd == 5'd1) return 2'd0;
    else                  return 2'(SHIFT_TAB[4'(5'd17 - rnd)]);
  endfunction

endpackage

// File: rtl/des_round.sv
// One DES Feistel round including the on-the-fly subkey (rotate + PC2).
// Purely combinational so several can be chained per clock.
module des_round
  import des_pkg::*;
(
  input  logic [4:0]  round_i,
  input  logic        decrypt_i,
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [27:0] c_i,
  input  logic [27:0] d_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o,
  output logic [27:0] c_o,
  output logic [27:0] d_o
);

  logic [1:0]  amt;
  logic [27:0] c_rot;
  logic [27:0] d_rot;
  logic [47:0] subkey;
  logic [31:0] f_out;

  // Subkey derivation and round function f(R, K)
  always_comb begin
    amt = round_shift(round_i, decrypt_i);
    if (decrypt_i) begin
      c_rot = rotr28(c_i, amt);
      d_rot = rotr28(d_i, amt);
    end else begin
      c_rot = rotl28(c_i, amt);
      d_rot = rotl28(d_i, amt);
    end
    subkey = des_pc2({c_rot, d_rot});
    f_out  = des_p(des_sbox(des_e(r_i) ^ subkey));
  end

  assign l_o = r_i;
  assign r_o = l_i ^ f_out;
  assign c_o = c_rot;
  assign d_o = d_rot;

endmodule

// File: rtl/des_iterative_engine.sv
// Iterative DES encrypt/decrypt engine, ROUNDS_PER_CYCLE rounds per clock.
// Optional CBC chaining is built when DES_ENGINE_CBC_EN is defined;
// otherwise the engine is ECB-only and in_iv / in_chain_start are ignored.
//
// state    | meaning
// ST_IDLE  | in_ready high, waiting for a request
// ST_ROUND | Feistel rounds in progress
// ST_DONE  | result held on out_data until out_ready
module des_iterative_engine
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  input  logic [63:0] in_iv,
  input  logic        in_chain_start,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  localparam int         NR        = ROUNDS_PER_CYCLE;
  localparam logic [4:0] STEP      = 5'(ROUNDS_PER_CYCLE);
  localparam logic [4:0] LAST_BASE = 5'(17 - ROUNDS_PER_CYCLE);

  generate
    if (!(NR == 1 || NR == 2 || NR == 4 || NR == 8 || NR == 16)) begin : g_bad_rounds
      $fatal(1, "des_iterative_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  des_state_e  state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [63:0] out_data_q;
  logic        decrypt_q;
  logic [4:0]  round_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;

  logic [NR:0][31:0] l_w, r_w;
  logic [NR:0][27:0] c_w, d_w;

  logic [63:0] core_in;
  logic [63:0] core_res;
  logic [63:0] result_w;
  logic [63:0] ip_w;
  logic [55:0] pc1_w;
  logic        accept;
  logic        out_fire;

  // in_ready_q is only ever high in ST_IDLE, so it doubles as the state qualifier
  assign accept   = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  assign ip_w     = des_ip(core_in);
  assign pc1_w    = des_pc1(in_key);
  assign core_res = des_fp({r_w[NR], l_w[NR]});

  assign l_w[0] = l_q;
  assign r_w[0] = r_q;
  assign c_w[0] = c_q;
  assign d_w[0] = d_q;

  generate
    for (genvar g = 0; g < NR; g++) begin : g_round
      des_round u_round (
        .round_i   (round_q + 5'(g)),
        .decrypt_i (decrypt_q),
        .l_i       (l_w[g]),
        .r_i       (r_w[g]),
        .c_i       (c_w[g]),
        .d_i       (d_w[g]),
        .l_o       (l_w[g+1]),
        .r_o       (r_w[g+1]),
        .c_o       (c_w[g+1]),
        .d_o       (d_w[g+1])
      );
    end
  endgenerate

`ifdef DES_ENGINE_CBC_EN
  logic [63:0] chain_q;
  logic [63:0] blk_in_q;
  logic [63:0] chain_sel;

  assign chain_sel = in_chain_start ? in_iv : chain_q;
  assign core_in   = in_decrypt ? in_data : (in_data ^ chain_sel);
  assign result_w  = decrypt_q ? (core_res ^ chain_q) : core_res;

  // Chain register: IV load at accept, advance on the output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q  <= '0;
      blk_in_q <= '0;
    end else if (accept) begin
      chain_q  <= chain_sel;
      blk_in_q <= in_data;
    end else if (out_fire) begin
      chain_q  <= decrypt_q ? blk_in_q : out_data_q;
    end
  end
`else
  logic unused_ecb_inputs;
  assign unused_ecb_inputs = ^{in_iv, in_chain_start};
  assign core_in  = in_data;
  assign result_w = core_res;
`endif

  // Control FSM with registered handshake outputs and round datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      decrypt_q   <= 1'b0;
      round_q     <= 5'd1;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            l_q        <= ip_w[63:32];
            r_q        <= ip_w[31:0];
            c_q        <= pc1_w[55:28];
            d_q        <= pc1_w[27:0];
            decrypt_q  <= in_decrypt;
            round_q    <= 5'd1;
            in_ready_q <= 1'b0;
            state_q    <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          l_q     <= l_w[NR];
          r_q     <= r_w[NR];
          c_q     <= c_w[NR];
          d_q     <= d_w[NR];
          round_q <= round_q + STEP;
          if (round_q == LAST_BASE) begin
            out_data_q  <= result_w;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
